xor_addsub_pipe: RTL and testbench
==================================

Name: xor_addsub_pipe

Overview:
Parametrised two-stage pipelined add/subtract unit for the CORDIC square-root datapath. Subtraction is done by bitwise-XOR operand inversion plus carry-in, the vector generalisation of the single-bit XOR gate used for rotation-direction control. It sits between the iteration controller and the x/y residual registers. It has valid/ready handshakes on both sides, so CORDIC stages can stall without losing operands.

Parameters:
WIDTH, 16, operand and result width in bits (two's complement), legal range 4..64.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  minuend/augend
in_b  input  WIDTH  subtrahend/addend
in_sub  input  1  0 = a+b, 1 = a-b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result
out_carry  output  1  carry-out of the WIDTH-bit add; for sub, 1 = no borrow
out_ovf  output  1  signed overflow flag

Behaviour:
- Reset (async assert, sync release):
  - s1_valid, s2_valid, out_valid = 0
  - out_sum = 0; out_carry = 0; out_ovf = 0
  - all stage registers = 0
  - in_ready = 1 in the first cycle after reset release.
- Stage 1 (operand stage), captured on accept (in_valid && in_ready):
  - s1_a = in_a
  - s1_bx = in_b XOR {WIDTH{in_sub}}
  - s1_cin = in_sub
  - s1_valid = 1
- Stage 2 (result stage):
  - {carry, sum} = s1_a + s1_bx + s1_cin, computed at WIDTH+1 bits.
  - ovf = (s1_a[MSB] == s1_bx[MSB]) && (sum[MSB] != s1_a[MSB]).
  - Registered into out_* when stage 2 advances.
- Advance rules (elastic pipeline):
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - s1_adv = in_valid && (!s1_valid || s2_adv)
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no combinational path from in_valid).
- Result consumption:
  - When out_valid && out_ready && !s2_adv: out_valid clears next cycle.
  - When s2_adv: out_valid = 1 with the new result.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput: 1 result/cycle.
- Stall: while out_valid && !out_ready, out_sum, out_carry and out_ovf hold stable. Stage 1 holds one additional operand set, so capacity is 2 in flight. A third operand sees in_ready = 0.
- Simultaneous accept and drain: in a full pipeline with out_ready = 1, stage 2 and stage 1 both advance in the same cycle. in_ready = 1 and there are no bubbles.
- Wrap-around: sum is modulo 2^WIDTH. Carry and ovf are reported, never trapped.
- Boundary: a - a gives 0 with carry = 1 and ovf = 0. 0 - 1 gives all-ones with carry = 0.
- Reset mid-operation: in-flight operands are discarded, valids drop asynchronously, and no partial result appears after release.

Optional Feature:
Macro XOR_ADDSUB_SATURATE_EN.
- Defined: on ovf = 1, out_sum clamps to signed max (0111..1) when s1_a[MSB] = 0, or to signed min (1000..0) when s1_a[MSB] = 1. out_ovf is still asserted; out_carry is unchanged.
- Undefined: out_sum wraps modulo 2^WIDTH. The saturation logic is absent from the netlist.

Decomposition:
- Shared package cordic_pkg:
  - localparams OP_ADD = 1'b0 and OP_SUB = 1'b1
  - function sat_max(width) and function sat_min(width), used by this block and future CORDIC stages.
- One sub-module, xor_vec: WIDTH-parametrised combinational bitwise XOR of a vector with a broadcast control bit. It is instantiated in stage 1 for the operand inversion.

Test Plan:
1. Add (WIDTH = 16): a = 0x0003, b = 0x0005, sub = 0, out_ready held 1 -> out_valid exactly 2 cycles after accept, sum = 0x0008, carry = 0, ovf = 0.
2. Subtract: a = 0x0005, b = 0x0003, sub = 1 -> sum = 0x0002, carry = 1. Then a = 0x0000, b = 0x0001, sub = 1 -> sum = 0xFFFF, carry = 0, ovf = 0.
3. Overflow: a = 0x7FFF, b = 0x0001, add -> ovf = 1; sum = 0x8000, or 0x7FFF with XOR_ADDSUB_SATURATE_EN. Also a = 0x8000, b = 0x0001, sub -> ovf = 1; sum = 0x7FFF, or 0x8000 saturated.
4. Backpressure:
   - Stimulus: stream 4 operand sets; hold out_ready = 0 for 5 cycles, then release.
   - in_ready drops after 2 accepts and outputs stay stable while stalled.
   - Results emerge in order with no loss or duplication, and 1/cycle after release.
5. Back-to-back throughput: 8 random operand sets on consecutive cycles with out_ready = 1 -> 8 consecutive out_valid cycles matching the reference model, with in_ready never deasserted.
6. Reset mid-operation: assert rst asynchronously with 2 ops in flight -> out_valid falls within the same cycle, out_sum = 0, and there is no out_valid after release until a new accept.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: add/sub opcodes and signed saturation limits,
// sized up to 64 bits and sliced down by each user to its own width.
package cordic_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/xor_addsub_pipe_xor_vec.sv
// Conditional vector inversion: every bit of i_vec is XORed with i_ctl.
module xor_vec #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_vec,
    input  logic             i_ctl,
    output logic [WIDTH-1:0] o_vec
);

    assign o_vec = i_vec ^ {WIDTH{i_ctl}};

endmodule

// File: rtl/xor_addsub_pipe.sv
// Two-stage elastic add/subtract unit; subtraction is a + ~b + 1.
// Define XOR_ADDSUB_SATURATE_EN to clamp overflowing results to signed max/min.
module xor_addsub_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned MSB = WIDTH - 1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_bx;
    logic             r_s1_cin;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_carry;
    logic             r_out_ovf;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_full;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    xor_vec #(.WIDTH(WIDTH)) u_xor_vec (
        .i_vec (in_b),
        .i_ctl (in_sub == OP_SUB),
        .o_vec (w_bx)
    );

    // Stage 1 may refill in the same cycle stage 2 drains, so no bubbles.
    assign w_s2_adv = r_s1_valid && (!r_out_valid || out_ready);
    assign w_s1_adv = in_valid && (!r_s1_valid || w_s2_adv);
    assign in_ready = !r_s1_valid || w_s2_adv;

    assign w_full = {1'b0, r_s1_a} + {1'b0, r_s1_bx} + {{WIDTH{1'b0}}, r_s1_cin};
    assign w_ovf  = (r_s1_a[MSB] == r_s1_bx[MSB]) && (w_full[MSB] != r_s1_a[MSB]);

`ifdef XOR_ADDSUB_SATURATE_EN
    localparam logic [63:0] SAT_HI = sat_max(WIDTH);
    localparam logic [63:0] SAT_LO = sat_min(WIDTH);

    always_comb begin
        w_res = w_full[WIDTH-1:0];
        if (w_ovf) begin
            w_res = r_s1_a[MSB] ? SAT_LO[WIDTH-1:0] : SAT_HI[WIDTH-1:0];
        end
    end
`else
    assign w_res = w_full[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_bx    <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_bx    <= w_bx;
            r_s1_cin   <= in_sub;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_res;
            r_out_carry <= w_full[WIDTH];
            r_out_ovf   <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_xor_addsub_pipe.sv
// Directed bench for xor_addsub_pipe with an arithmetic reference model and
// an every-cycle output scoreboard. Honours XOR_ADDSUB_SATURATE_EN.
module tb_xor_addsub_pipe;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors;
    int   checks;
    int   run_len;
    int   max_run;

    xor_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: true integer arithmetic, then reduce to W bits and flags.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t   e;
        longint ua, ub, sa, sb, raw, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            raw     = ua - ub;
            e.carry = (ua >= ub);
            sres    = sa - sb;
        end else begin
            raw     = ua + ub;
            e.carry = (raw >= 65536);
            sres    = sa + sb;
        end
        e.ovf = (sres > 32767) || (sres < -32768);
        e.sum = W'(raw & 64'hFFFF);
`ifdef XOR_ADDSUB_SATURATE_EN
        if (e.ovf) e.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
        return e;
    endfunction

    // Scoreboard: inputs change at posedge+1, everything sampled at negedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            run_len = 0;
        end else begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("sb_sum",   longint'(out_sum),   longint'(exp_q[0].sum));
                    check("sb_carry", longint'(out_carry), longint'(exp_q[0].carry));
                    check("sb_ovf",   longint'(out_ovf),   longint'(exp_q[0].ovf));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output int waits);
        logic acc;
        waits    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
            waits++;
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sub   = 1'b0;
    endtask

    task automatic one_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] xs, input logic xc, input logic xo);
        int  w;
        bit  seen;
        send(a, b, sub, w);
        idle();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                check({name, "_sum"},   longint'(out_sum),   longint'(xs));
                check({name, "_carry"}, longint'(out_carry), longint'(xc));
                check({name, "_ovf"},   longint'(out_ovf),   longint'(xo));
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int total_waits;
        errors    = 0;
        checks    = 0;
        run_len   = 0;
        max_run   = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();

        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum",   longint'(out_sum),   0);
        check("rst_out_carry", longint'(out_carry), 0);
        check("rst_out_ovf",   longint'(out_ovf),   0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1: add with exact latency
        send(16'h0003, 16'h0005, 1'b0, w);
        idle();
        @(negedge clk);
        check("lat_cycle1_valid", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2_valid", longint'(out_valid), 1);
        check("add_sum",   longint'(out_sum),   16'h0008);
        check("add_carry", longint'(out_carry), 0);
        check("add_ovf",   longint'(out_ovf),   0);
        @(posedge clk);
        #1;

        // 2: subtract and borrow
        one_op("sub_5_3", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        one_op("sub_0_1", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        one_op("sub_a_a", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

        // 3: signed overflow
`ifdef XOR_ADDSUB_SATURATE_EN
        one_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        one_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        one_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        one_op("carry_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // 4: backpressure, capacity two, ordered drain one per cycle
        out_ready = 1'b0;
        fork
            begin
                send(16'h1111, 16'h0001, 1'b0, w);
                send(16'h2222, 16'h0002, 1'b1, w);
                send(16'h3333, 16'h0003, 1'b0, w);
                send(16'h4444, 16'h0004, 1'b1, w);
                idle();
            end
            begin
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                check("bp_in_ready_full", longint'(in_ready), 0);
                check("bp_out_valid_held", longint'(out_valid), 1);
                @(negedge clk);
                check("bp_in_ready_still", longint'(in_ready), 0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_drain_valid", longint'(out_valid), 1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_queue_empty", longint'(exp_q.size()), 0);

        // 5: back-to-back random stream
        max_run     = 0;
        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(1)), w);
            total_waits += w;
        end
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("b2b_in_ready_stalls", longint'(total_waits), 0);
        check("b2b_valid_run", longint'(max_run), 8);
        check("b2b_queue_empty", longint'(exp_q.size()), 0);

        // 6: asynchronous reset with two operations in flight
        out_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0, w);
        send(16'h0300, 16'h0001, 1'b1, w);
        idle();
        @(posedge clk);
        #1;
        check("rst_mid_pre_valid", longint'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", longint'(out_valid), 0);
        check("rst_mid_out_sum",   longint'(out_sum),   0);
        check("rst_mid_in_ready",  longint'(in_ready),  1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_no_valid", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        one_op("after_rst", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
